// File: rtl/lp805x_syncarb.sv
// rtl/lp805x_syncarb.sv - round-robin write-side arbiter feeding the lp805x_syncg one-word handshake
module lp805x_syncarb #(
    parameter int N   = 4,
    parameter int DW  = 40,
    parameter int TMO = 255
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [N-1:0]          req,
    input  logic [N*DW-1:0]       req_data,
    output logic [N-1:0]          ack,
    output logic                  wput,
    input  logic                  wrdy,
    output logic [DW-1:0]         data_in,
    output logic [$clog2(N)-1:0]  grant_id,
    output logic                  busy,
    output logic                  err
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUT  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [7:0]      wdog_q, wdog_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            err_q, err_d;
    logic            wput_q, wput_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   data_q, data_d;
    logic [IW-1:0]   grant_q, grant_d;

    logic [IW-1:0]   win;
    logic            win_found;

    // Scan from the farthest offset down so the nearest requester after last_q wins.
    always_comb begin
        logic [IW-1:0] idx;
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int i = N; i >= 1; i--) begin
            idx = IW'((int'(last_q) + i) % N);
            if (req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst) begin
            state_q <= S_IDLE;
            last_q  <= IW'(N - 1);
            wdog_q  <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            wput_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            wput_q  <= wput_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (win_found && wrdy) state_d = S_PUT;
            S_PUT:   if (wrdy || (wdog_q == 8'(TMO))) state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        ack_d   = '0;
        err_d   = 1'b0;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (state_d == S_PUT) begin
                    data_d  = req_data[int'(win)*DW +: DW];
                    grant_d = win;
                    wdog_d  = '0;
                end
            end
            S_PUT: begin
                if (wrdy) begin
                    ack_d[grant_q] = 1'b1;
                    last_d         = grant_q;
                end else if (wdog_q == 8'(TMO)) begin
                    err_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: ;
        endcase
        wput_d = (state_d == S_PUT);
        busy_d = (state_d != S_IDLE);
    end

    assign ack      = ack_q;
    assign err      = err_q;
    assign wput     = wput_q;
    assign busy     = busy_q;
    assign data_in  = data_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_lp805x_syncarb.sv
// tb/tb_lp805x_syncarb.sv - directed self-checking bench for lp805x_syncarb
module tb_lp805x_syncarb;

    localparam int N   = 4;
    localparam int DW  = 40;
    localparam int TMO = 8;

    logic              wclk;
    logic              wrst;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      ack;
    logic              wput;
    logic              wrdy;
    logic [DW-1:0]     data_in;
    logic [1:0]        grant_id;
    logic              busy;
    logic              err;

    int n_checks;
    int n_errors;

    lp805x_syncarb #(.N(N), .DW(DW), .TMO(TMO)) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .wput     (wput),
        .wrdy     (wrdy),
        .data_in  (data_in),
        .grant_id (grant_id),
        .busy     (busy),
        .err      (err)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge wclk);
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        wrst     = 1'b0;
        req      = '0;
        req_data = '0;
        wrdy     = 1'b0;
        repeat (10) step();
        check("rst_wput", 64'(wput), 64'(0));
        check("rst_ack", 64'(ack), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_data", 64'(data_in), 64'(0));
        check("rst_gid", 64'(grant_id), 64'(0));
        wrst = 1'b1;

        // single request, channel ready
        req = 4'b0001;
        set_data(0, 40'hAA55);
        wrdy = 1'b1;
        step();
        check("s_wput", 64'(wput), 64'(1));
        check("s_data", 64'(data_in), 64'(40'hAA55));
        check("s_gid", 64'(grant_id), 64'(0));
        check("s_ack0", 64'(ack), 64'(0));
        step();
        check("s_ack", 64'(ack), 64'(4'b0001));
        check("s_wput_off", 64'(wput), 64'(0));
        req = '0;
        step();
        check("s_ack_pulse", 64'(ack), 64'(0));
        check("s_idle", 64'(busy), 64'(0));
        check("s_hold_data", 64'(data_in), 64'(40'hAA55));

        // fairness from a fresh pointer
        wrst = 1'b0;
        step();
        wrst = 1'b1;
        for (int i = 0; i < N; i++) set_data(i, DW'(i));
        req = 4'b1111;
        for (int t = 0; t < 6; t++) begin
            step();
            check("f_wput", 64'(wput), 64'(1));
            check("f_gid", 64'(grant_id), 64'(t % N));
            check("f_data", 64'(data_in), 64'(t % N));
            step();
            check("f_ack", 64'(ack), 64'(1 << (t % N)));
            check("f_noput", 64'(wput), 64'(0));
            step();
            check("f_idle", 64'(busy), 64'(0));
        end
        req = '0;
        step();

        // backpressure in IDLE, then while in PUT
        req  = 4'b0100;
        set_data(2, 40'hFFFF550000);
        wrdy = 1'b0;
        for (int t = 0; t < 20; t++) begin
            step();
            check("bp_nogrant", 64'({busy, wput}), 64'(0));
        end
        wrdy = 1'b1;
        step();
        check("bp_wput", 64'(wput), 64'(1));
        check("bp_gid", 64'(grant_id), 64'(2));
        wrdy = 1'b0;
        for (int t = 0; t < 3; t++) begin
            step();
            check("bp_hold_put", 64'(wput), 64'(1));
            check("bp_data", 64'(data_in), 64'(40'hFFFF550000));
            check("bp_noack", 64'(ack), 64'(0));
        end
        wrdy = 1'b1;
        step();
        check("bp_ack", 64'(ack), 64'(4'b0100));
        req = '0;
        step();

        // watchdog: last is 2, so requester 0 wins among {0,1}
        req = 4'b0011;
        set_data(0, 40'h100);
        set_data(1, 40'h101);
        step();
        check("wd_gid", 64'(grant_id), 64'(0));
        check("wd_data", 64'(data_in), 64'(40'h100));
        wrdy = 1'b0;
        for (int t = 0; t < TMO; t++) begin
            step();
            check("wd_put", 64'({wput, err, ack}), 64'(6'b100000));
        end
        step();
        check("wd_err", 64'(err), 64'(1));
        check("wd_wput", 64'(wput), 64'(0));
        check("wd_noack", 64'(ack), 64'(0));
        wrdy = 1'b1;
        step();
        check("wd_err_pulse", 64'(err), 64'(0));
        check("wd_idle", 64'(busy), 64'(0));
        step();
        check("wd_regrant", 64'(grant_id), 64'(0));
        check("wd_regrant_put", 64'(wput), 64'(1));
        step();
        check("wd_ack", 64'(ack), 64'(4'b0001));
        req = '0;
        step();

        // withdraw during PUT
        req = 4'b0010;
        set_data(1, 40'h2222);
        step();
        check("wr_gid", 64'(grant_id), 64'(1));
        req = '0;
        step();
        check("wr_ack", 64'(ack), 64'(4'b0010));
        check("wr_data", 64'(data_in), 64'(40'h2222));
        step();

        // reset mid-PUT: last is 1, so 3 wins first; after reset 0 must win
        req = 4'b1001;
        set_data(3, 40'h3333);
        set_data(0, 40'h0A0A);
        step();
        check("rp_gid", 64'(grant_id), 64'(3));
        check("rp_wput", 64'(wput), 64'(1));
        wrdy = 1'b0;
        wrst = 1'b0;
        step();
        check("rp_wput0", 64'(wput), 64'(0));
        check("rp_busy0", 64'(busy), 64'(0));
        check("rp_noack", 64'(ack), 64'(0));
        check("rp_data0", 64'(data_in), 64'(0));
        wrst = 1'b1;
        wrdy = 1'b1;
        step();
        check("rp_first", 64'(grant_id), 64'(0));
        check("rp_first_data", 64'(data_in), 64'(40'h0A0A));
        step();
        check("rp_ack", 64'(ack), 64'(4'b0001));
        req = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
